// File: rtl/fe_resteer_arb.sv
// Frontend resteer arbiter: per-source redirect slots resolved by program age.
// Optional ROB squash window enabled by defining RESTEER_SQUASH_EN.
module fe_resteer_arb #(
    parameter int XLEN       = 32,
    parameter int CLC_WIDTH  = 28,
    parameter int SQUASH_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_in,
    input  logic                 req_rob,
    input  logic                 req_br,
    input  logic                 req_d1,
    input  logic                 req_ras,
    input  logic [XLEN-1:0]      tgt_rob,
    input  logic [XLEN-1:0]      tgt_br,
    input  logic [XLEN-1:0]      tgt_d1,
    input  logic [XLEN-1:0]      tgt_ras,
    output logic                 resteer,
    output logic [XLEN-1:0]      resteer_target,
    output logic [CLC_WIDTH-1:0] resteer_line,
    output logic [1:0]           resteer_src,
    output logic [3:0]           pending_mask,
    output logic                 squash_active
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        SQUASH = 2'd2
    } state_t;

    state_t state, state_d;

    logic [3:0]           slot_v, v_d;
    logic [3:0][XLEN-1:0] slot_t, t_d, tgt;
    logic [3:0]           req, req_ok, acc;
    logic                 hit, seen_old;
    logic                 iss, rob_iss;
    logic [1:0]           iss_idx;
    logic [XLEN-1:0]      iss_tgt;
    logic                 squash_on;

`ifdef RESTEER_SQUASH_EN
    logic [3:0] sq_cnt, sq_cnt_d;
    assign squash_on = (sq_cnt != 4'd0);
`else
    assign squash_on = 1'b0;
`endif

    assign req = {req_ras, req_d1, req_br, req_rob};
    assign tgt = {tgt_ras, tgt_d1, tgt_br, tgt_rob};

    // Index 0 is the oldest source (ROB); higher indices are younger.
    always_comb begin
        req_ok   = req;
        acc      = 4'b0000;
        hit      = 1'b0;
        seen_old = 1'b0;
        if (squash_on)
            req_ok[3:1] = 3'b000;
        for (int i = 0; i < 4; i++) begin
            if (!hit && req_ok[i]) begin
                hit = 1'b1;
                if (!seen_old)
                    acc[i] = 1'b1;
            end
            seen_old = seen_old | slot_v[i];
        end
    end

    always_comb begin
        v_d     = slot_v;
        t_d     = slot_t;
        iss_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (acc[i] && j > i)
                    v_d[j] = 1'b0;
            end
            if (acc[i]) begin
                v_d[i] = 1'b1;
                t_d[i] = tgt[i];
            end
        end
        iss = !stall_in && (v_d != 4'b0000);
        for (int i = 3; i >= 0; i--) begin
            if (v_d[i])
                iss_idx = 2'(i);
        end
        iss_tgt = t_d[iss_idx];
        if (iss)
            v_d[iss_idx] = 1'b0;
        rob_iss = iss && (iss_idx == 2'd0);
    end

`ifdef RESTEER_SQUASH_EN
    always_comb begin
        sq_cnt_d = (sq_cnt != 4'd0) ? sq_cnt - 4'd1 : 4'd0;
        if (rob_iss)
            sq_cnt_d = 4'(SQUASH_CYC);
    end
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (v_d != 4'b0000)
                    state_d = PEND;
`ifdef RESTEER_SQUASH_EN
                else if (rob_iss)
                    state_d = SQUASH;
`endif
            end
            PEND: begin
                if (v_d != 4'b0000)
                    state_d = PEND;
`ifdef RESTEER_SQUASH_EN
                else if (rob_iss)
                    state_d = SQUASH;
`endif
                else
                    state_d = IDLE;
            end
`ifdef RESTEER_SQUASH_EN
            SQUASH: begin
                if (v_d != 4'b0000)
                    state_d = PEND;
                else if (rob_iss)
                    state_d = SQUASH;
                else if (sq_cnt_d == 4'd0)
                    state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            slot_v         <= 4'b0000;
            slot_t         <= '0;
            resteer        <= 1'b0;
            resteer_target <= '0;
            resteer_src    <= 2'd0;
        end else begin
            state   <= state_d;
            slot_v  <= v_d;
            slot_t  <= t_d;
            resteer <= iss;
            if (iss) begin
                resteer_target <= iss_tgt;
                resteer_src    <= iss_idx;
            end
        end
    end

`ifdef RESTEER_SQUASH_EN
    always_ff @(posedge clk) begin
        if (rst)
            sq_cnt <= 4'd0;
        else
            sq_cnt <= sq_cnt_d;
    end
`endif

    assign pending_mask  = slot_v;
    assign squash_active = squash_on;
    assign resteer_line  = resteer_target[4 +: CLC_WIDTH];

endmodule
